// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one registered 4-bit ALU between NREQ requesters.
// Optional build macro ALU_SHADOW_CHECK_EN adds a golden-model check of every captured ALU result.
module alu_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0] req_op,
  output logic [3:0]        alu_A,
  output logic [3:0]        alu_B,
  output logic [1:0]        alu_op,
  input  logic [3:0]        alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_result,
  output logic              rsp_carry,
  output logic              rsp_zero,
  output logic              busy,
  output logic              rsp_mismatch,
  output logic [7:0]        mismatch_cnt
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t         r_state, w_next;
  logic [IDW-1:0] r_ptr, r_id, w_win, w_cand;
  logic [2:0]     r_cnt;
  logic           w_found, w_cap;
  // First valid requester searched upward from ptr+1, wrapping modulo NREQ
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end
  // Next state and combinational grant
  always_comb begin
    req_ready = (r_state == IDLE && w_found) ? NREQ'(1) << w_win : '0;
    w_next    = r_state == IDLE ? (w_found ? WAIT : IDLE) :
                r_state == WAIT ? (r_cnt == 3'd0 ? RESP : WAIT) :
                                  (rsp_ready ? IDLE : RESP);
  end
  assign w_cap     = r_state == WAIT && r_cnt == 3'd0;
  assign rsp_valid = r_state == RESP;
  assign busy      = r_state != IDLE;
  assign rsp_id    = r_id;
  // State, operand latch on acceptance, latency count and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= IDW'(NREQ - 1);
      r_id       <= '0;
      r_cnt      <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_op     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_found) begin
        alu_A  <= req_a[4*w_win +: 4];
        alu_B  <= req_b[4*w_win +: 4];
        alu_op <= req_op[2*w_win +: 2];
        r_id   <= w_win;
        r_ptr  <= w_win;
        r_cnt  <= 3'(ALU_LAT);
      end
      if (r_state == WAIT && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
      if (w_cap) begin
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
        rsp_zero   <= alu_zero;
      end
    end
  end
`ifdef ALU_SHADOW_CHECK_EN
  logic [4:0] w_exp;
  logic       w_miss;
  logic       r_mis;
  logic [7:0] r_mcnt;
  // Golden {carry, result} from the operands the ALU is currently holding
  always_comb begin
    w_exp  = alu_op == 2'd0 ? {1'b0, alu_A} + {1'b0, alu_B} :
             alu_op == 2'd1 ? {alu_A < alu_B, alu_A - alu_B} :
             alu_op == 2'd2 ? {1'b0, alu_A & alu_B} : {1'b0, alu_A | alu_B};
    w_miss = {alu_carry, alu_result, alu_zero} != {w_exp, w_exp[3:0] == 4'd0};
  end
  // Flag and saturating count of disagreements, evaluated at capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mis  <= 1'b0;
      r_mcnt <= '0;
    end else if (w_cap) begin
      r_mis <= w_miss;
      if (w_miss && r_mcnt != 8'hff) r_mcnt <= r_mcnt + 8'd1;
    end
  end
  assign rsp_mismatch = r_mis;
  assign mismatch_cnt = r_mcnt;
`else
  assign rsp_mismatch = 1'b0;
  assign mismatch_cnt = '0;
`endif
endmodule
